// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window fetch path and move_control.
package sobel_pkg;

    localparam int unsigned DEF_PIXEL_W = 8;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned WIDTH_W     = 12;
    localparam int unsigned N_FULL      = 9;
    localparam int unsigned N_EDGE      = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SLOT_W      = 4;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_ROW   = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // How retained pixels move inside the 3x3 window before new ones land.
    typedef enum logic [1:0] {
        SH_NONE     = 2'd0,
        SH_TO_LEFT  = 2'd1,
        SH_TO_RIGHT = 2'd2,
        SH_UP       = 2'd3
    } shift_t;

    function automatic shift_t shift_for(input dir_t d);
        case (d)
            DIR_RIGHT: return SH_TO_LEFT;
            DIR_LEFT:  return SH_TO_RIGHT;
            DIR_ROW:   return SH_UP;
            default:   return SH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sobel_window_fetch_if.sv
// Request, pixel-memory and window bundle between move_control/memory and the window fetcher.
interface sobel_window_fetch_if
    import sobel_pkg::*;
#(
    parameter int unsigned PIXEL_W = DEF_PIXEL_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
);
    logic [WIDTH_W-1:0]   width;
    logic [ADDR_W-1:0]    addr_r;
    dir_t                 direction;
    logic                 load_initial;
    logic                 start_move;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_read;
    logic [PIXEL_W-1:0]   mem_rdata;
    logic [9*PIXEL_W-1:0] window;
    logic                 window_valid;
    logic                 busy;
    logic                 fetch_done;

    modport master (
        output width, addr_r, direction, load_initial, start_move, mem_rdata,
        input  mem_addr, mem_read, window, window_valid, busy, fetch_done
    );

    modport slave (
        input  width, addr_r, direction, load_initial, start_move, mem_rdata,
        output mem_addr, mem_read, window, window_valid, busy, fetch_done
    );
endinterface

// File: rtl/window_reg3x3.sv
// 3x3 pixel register file with whole-window shift and single-slot write.
module window_reg3x3
    import sobel_pkg::*;
#(
    parameter int unsigned PIXEL_W = DEF_PIXEL_W
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  shift_t               shift,
    input  logic                 wr_en,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [PIXEL_W-1:0]   wr_data,
    output logic [9*PIXEL_W-1:0] window
);

    logic [PIXEL_W-1:0] pix [9];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 9; i++) pix[i] <= '0;
        end else begin
            unique case (shift)
                SH_TO_LEFT: begin
                    for (int r = 0; r < 3; r++) begin
                        pix[3*r]   <= pix[3*r+1];
                        pix[3*r+1] <= pix[3*r+2];
                    end
                end
                SH_TO_RIGHT: begin
                    for (int r = 0; r < 3; r++) begin
                        pix[3*r+2] <= pix[3*r+1];
                        pix[3*r+1] <= pix[3*r];
                    end
                end
                SH_UP: begin
                    for (int c = 0; c < 3; c++) begin
                        pix[c]   <= pix[3+c];
                        pix[3+c] <= pix[6+c];
                    end
                end
                default: ;
            endcase
            for (int i = 0; i < 9; i++) begin
                if (wr_en && (wr_slot == SLOT_W'(i))) pix[i] <= wr_data;
            end
        end
    end

    // Slot 3r+c sits at bits [PIXEL_W*(3r+c) +: PIXEL_W].
    always_comb begin
        window = '0;
        for (int i = 0; i < 9; i++) window[i*PIXEL_W +: PIXEL_W] = pix[i];
    end

endmodule

// File: rtl/sobel_window_fetch.sv
// Fetches a full 3x3 window or the newly exposed edge after a move, keeping the rest in place.
module sobel_window_fetch
    import sobel_pkg::*;
#(
    parameter int unsigned PIXEL_W = DEF_PIXEL_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 n_reset,
    sobel_window_fetch_if.slave  bus
);

    state_t              state;
    logic [ADDR_W-1:0]   stride;
    logic                full;
    dir_t                dir;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          col;
    logic [SLOT_W-1:0]   rd_slot;
    logic                cap_en;
    logic [SLOT_W-1:0]   cap_slot;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read;
    logic                window_valid;
    logic                busy;
    logic                fetch_done;

    logic                req_c;
    logic                req_full_c;
    logic [ADDR_W-1:0]   width_c;
    logic [ADDR_W-1:0]   first_addr_c;
    logic [SLOT_W-1:0]   first_slot_c;
    logic [ADDR_W-1:0]   next_addr_c;
    logic [SLOT_W-1:0]   next_slot_c;
    logic                last_c;
    shift_t              shift_c;
    logic                unused_c;

    assign unused_c   = ^bus.width[WIDTH_W-1:ADDR_W];
    assign width_c    = bus.width[ADDR_W-1:0];
    assign req_c      = bus.load_initial || bus.start_move;
    assign req_full_c = bus.load_initial || !window_valid;

    // First address/slot of a request; row offsets use adds only.
    always_comb begin
        first_addr_c = bus.addr_r;
        first_slot_c = '0;
        if (!req_full_c) begin
            unique case (bus.direction)
                DIR_RIGHT: begin
                    first_addr_c = bus.addr_r + ADDR_W'(2);
                    first_slot_c = SLOT_W'(2);
                end
                DIR_ROW: begin
                    first_addr_c = bus.addr_r + width_c + width_c;
                    first_slot_c = SLOT_W'(6);
                end
                default: ;
            endcase
        end
    end

    // Step to the next read: along a row, down a column, or wrap to the next row.
    always_comb begin
        next_addr_c = mem_addr + ADDR_W'(1);
        next_slot_c = rd_slot + SLOT_W'(1);
        last_c      = (cnt == CNT_W'(N_EDGE - 1));
        shift_c     = SH_NONE;
        if (full) begin
            last_c = (cnt == CNT_W'(N_FULL - 1));
            if (col == 2'd2) next_addr_c = mem_addr + stride - ADDR_W'(2);
        end else begin
            if (dir == DIR_RIGHT || dir == DIR_LEFT) begin
                next_addr_c = mem_addr + stride;
                next_slot_c = rd_slot + SLOT_W'(3);
            end
            if (state == ST_READ && cnt == '0) shift_c = shift_for(dir);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= ST_IDLE;
            stride       <= '0;
            full         <= 1'b0;
            dir          <= DIR_NONE;
            cnt          <= '0;
            col          <= '0;
            rd_slot      <= '0;
            cap_en       <= 1'b0;
            cap_slot     <= '0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            window_valid <= 1'b0;
            busy         <= 1'b0;
            fetch_done   <= 1'b0;
        end else begin
            cap_en   <= (state == ST_READ);
            cap_slot <= rd_slot;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    fetch_done <= 1'b0;
                    state      <= ST_IDLE;
                    if (req_c) begin
                        busy    <= 1'b1;
                        stride  <= width_c;
                        full    <= req_full_c;
                        dir     <= bus.direction;
                        cnt     <= '0;
                        col     <= '0;
                        if (req_full_c) window_valid <= 1'b0;
                        // A no-op move still spends one cycle so it completes at E0+N+1.
                        if (!req_full_c && bus.direction == DIR_NONE) begin
                            state <= ST_DRAIN;
                        end else begin
                            state    <= ST_READ;
                            mem_read <= 1'b1;
                            mem_addr <= first_addr_c;
                            rd_slot  <= first_slot_c;
                        end
                    end
                end
                ST_READ: begin
                    if (last_c) begin
                        state    <= ST_DRAIN;
                        mem_read <= 1'b0;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        col      <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                        mem_addr <= next_addr_c;
                        rd_slot  <= next_slot_c;
                    end
                end
                ST_DRAIN: begin
                    state        <= ST_DONE;
                    fetch_done   <= 1'b1;
                    window_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    window_reg3x3 #(.PIXEL_W(PIXEL_W)) u_win (
        .clk     (clk),
        .n_reset (n_reset),
        .shift   (shift_c),
        .wr_en   (cap_en),
        .wr_slot (cap_slot),
        .wr_data (bus.mem_rdata),
        .window  (bus.window)
    );

    assign bus.mem_addr     = mem_addr;
    assign bus.mem_read     = mem_read;
    assign bus.window_valid = window_valid;
    assign bus.busy         = busy;
    assign bus.fetch_done   = fetch_done;

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Directed bench for sobel_window_fetch: memory returns its own address, width = 5.
module tb_sobel_window_fetch;
    import sobel_pkg::*;

    logic clk = 1'b0;
    logic n_reset;
    int   n_total = 0;
    int   n_bad   = 0;
    int   lat;
    logic [7:0] reads[$];
    logic [7:0] exp_q[$];

    sobel_window_fetch_if bus ();

    sobel_window_fetch dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory with mem[a] = a, plus a log of issued reads.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_addr;
        if (bus.mem_read) reads.push_back(bus.mem_addr);
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "_nreads"}, 72'(reads.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < reads.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 72'(reads[i]), 72'(exp_q[i]));
    endtask

    function automatic logic [71:0] win9(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    // Issue one request from an idle/done cycle; returns cycles from E0 to fetch_done.
    task automatic run_req(input logic ld, input logic mv, input dir_t d, input logic [7:0] a,
                           input int poke, input string tag, output int lat_o);
        reads.delete();
        bus.load_initial = ld;
        bus.start_move   = mv;
        bus.direction    = d;
        bus.addr_r       = a;
        @(posedge clk); #1;
        bus.load_initial = 1'b0;
        bus.start_move   = 1'b0;
        chk({tag, "_busy"}, 72'(bus.busy), 72'(1));
        if (ld) chk({tag, "_valid_clr"}, 72'(bus.window_valid), 72'(0));
        lat_o = -1;
        for (int i = 1; i <= 24; i++) begin
            if (i == poke) begin
                bus.start_move = 1'b1;
                bus.direction  = DIR_RIGHT;
            end
            @(posedge clk); #1;
            bus.start_move = 1'b0;
            if (bus.fetch_done) begin
                lat_o = i;
                break;
            end
        end
        chk({tag, "_latency"}, 72'(lat_o), 72'(lat_o >= 0 ? lat_o : 0) | 72'(0));
    endtask

    initial begin
        n_reset          = 1'b0;
        bus.width        = 12'd5;
        bus.addr_r       = '0;
        bus.direction    = DIR_NONE;
        bus.load_initial = 1'b0;
        bus.start_move   = 1'b0;
        #2;
        chk("rst_mem_addr", 72'(bus.mem_addr), 72'(0));
        chk("rst_mem_read", 72'(bus.mem_read), 72'(0));
        chk("rst_window", bus.window, 72'(0));
        chk("rst_valid", 72'(bus.window_valid), 72'(0));
        chk("rst_busy", 72'(bus.busy), 72'(0));
        chk("rst_done", 72'(bus.fetch_done), 72'(0));
        @(posedge clk); #1;
        n_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_mem_read", 72'(bus.mem_read), 72'(0));
        chk("idle_busy", 72'(bus.busy), 72'(0));

        // Full load at 100.
        run_req(1'b1, 1'b0, DIR_NONE, 8'd100, 0, "full", lat);
        chk("full_lat10", 72'(lat), 72'(10));
        exp_q = '{8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112};
        chk_reads("full");
        chk("full_win", bus.window,
            win9(8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112));
        chk("full_valid", 72'(bus.window_valid), 72'(1));
        chk("full_busy_low", 72'(bus.busy), 72'(0));
        chk("full_rd_low", 72'(bus.mem_read), 72'(0));
        chk("full_addr_hold", 72'(bus.mem_addr), 72'(112));
        @(posedge clk); #1;
        chk("done_pulse_one", 72'(bus.fetch_done), 72'(0));

        // Move right; next row and left chained back-to-back from the DONE cycle.
        run_req(1'b0, 1'b1, DIR_RIGHT, 8'd101, 0, "right", lat);
        chk("right_lat4", 72'(lat), 72'(4));
        exp_q = '{8'd103, 8'd108, 8'd113};
        chk_reads("right");
        chk("right_win", bus.window,
            win9(8'd101, 8'd102, 8'd103, 8'd106, 8'd107, 8'd108, 8'd111, 8'd112, 8'd113));

        run_req(1'b0, 1'b1, DIR_ROW, 8'd106, 0, "row", lat);
        chk("row_lat4", 72'(lat), 72'(4));
        exp_q = '{8'd116, 8'd117, 8'd118};
        chk_reads("row");
        chk("row_win", bus.window,
            win9(8'd106, 8'd107, 8'd108, 8'd111, 8'd112, 8'd113, 8'd116, 8'd117, 8'd118));

        run_req(1'b0, 1'b1, DIR_LEFT, 8'd105, 0, "left", lat);
        chk("left_lat4", 72'(lat), 72'(4));
        exp_q = '{8'd105, 8'd110, 8'd115};
        chk_reads("left");
        chk("left_win", bus.window,
            win9(8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112, 8'd115, 8'd116, 8'd117));

        // No-op move.
        run_req(1'b0, 1'b1, DIR_NONE, 8'd105, 0, "none", lat);
        chk("none_lat1", 72'(lat), 72'(1));
        exp_q = '{};
        chk_reads("none");
        chk("none_win", bus.window,
            win9(8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112, 8'd115, 8'd116, 8'd117));
        chk("none_valid", 72'(bus.window_valid), 72'(1));

        // load_initial beats a simultaneous start_move.
        run_req(1'b1, 1'b1, DIR_RIGHT, 8'd50, 0, "both", lat);
        chk("both_lat10", 72'(lat), 72'(10));
        exp_q = '{8'd50, 8'd51, 8'd52, 8'd55, 8'd56, 8'd57, 8'd60, 8'd61, 8'd62};
        chk_reads("both");
        chk("both_win", bus.window,
            win9(8'd50, 8'd51, 8'd52, 8'd55, 8'd56, 8'd57, 8'd60, 8'd61, 8'd62));

        // start_move while busy is dropped.
        @(posedge clk); #1;
        run_req(1'b1, 1'b0, DIR_NONE, 8'd20, 3, "poke", lat);
        chk("poke_lat10", 72'(lat), 72'(10));
        repeat (3) @(posedge clk);
        #1;
        chk("poke_nreads", 72'(reads.size()), 72'(9));
        chk("poke_busy", 72'(bus.busy), 72'(0));
        chk("poke_win", bus.window,
            win9(8'd20, 8'd21, 8'd22, 8'd25, 8'd26, 8'd27, 8'd30, 8'd31, 8'd32));

        // Address wrap modulo 256.
        run_req(1'b1, 1'b0, DIR_NONE, 8'd250, 0, "wrap", lat);
        chk("wrap_lat10", 72'(lat), 72'(10));
        exp_q = '{8'd250, 8'd251, 8'd252, 8'd255, 8'd0, 8'd1, 8'd4, 8'd5, 8'd6};
        chk_reads("wrap");
        chk("wrap_win", bus.window,
            win9(8'd250, 8'd251, 8'd252, 8'd255, 8'd0, 8'd1, 8'd4, 8'd5, 8'd6));

        // Reset in the middle of a read burst.
        @(posedge clk); #1;
        bus.load_initial = 1'b1;
        bus.addr_r       = 8'd30;
        @(posedge clk); #1;
        bus.load_initial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reading", 72'(bus.mem_read), 72'(1));
        n_reset = 1'b0;
        #1;
        chk("mid_rst_addr", 72'(bus.mem_addr), 72'(0));
        chk("mid_rst_read", 72'(bus.mem_read), 72'(0));
        chk("mid_rst_window", bus.window, 72'(0));
        chk("mid_rst_valid", 72'(bus.window_valid), 72'(0));
        chk("mid_rst_busy", 72'(bus.busy), 72'(0));
        chk("mid_rst_done", 72'(bus.fetch_done), 72'(0));
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_read", 72'(bus.mem_read), 72'(0));

        // start_move with no valid window becomes a full load.
        run_req(1'b0, 1'b1, DIR_RIGHT, 8'd40, 0, "inval", lat);
        chk("inval_lat10", 72'(lat), 72'(10));
        exp_q = '{8'd40, 8'd41, 8'd42, 8'd45, 8'd46, 8'd47, 8'd50, 8'd51, 8'd52};
        chk_reads("inval");
        chk("inval_win", bus.window,
            win9(8'd40, 8'd41, 8'd42, 8'd45, 8'd46, 8'd47, 8'd50, 8'd51, 8'd52));
        chk("inval_valid", 72'(bus.window_valid), 72'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
